dff_bank_arbiter: RTL

- Round-robin arbiter and sequencer for one shared WIDTH-bit register built from resettable D flip-flops.
- N_REQ requesters compete for write access; each requester supplies an operation (load/set/clear/toggle) and data.
- The block grants one requester at a time, commits the operation to the shared register, and acknowledges with a one-cycle pulse.
- It sits between the requesting logic and the storage flip-flops, so storage is never written by two sources in the same cycle.

---
 rtl/dff_bank_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin arbiter that lets one of N_REQ requesters
// load/set/clear/toggle a shared WIDTH-bit register per three-cycle transaction.
module dff_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int PTR_W = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       op,
  input  logic [N_REQ*WIDTH-1:0]   d,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         ack,
  output logic [WIDTH-1:0]         q,
  output logic                     busy,
  output logic [PTR_W-1:0]         last_id
);
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_COMMIT} state_t;
  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_sel;
  logic [PTR_W-1:0]   r_last;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_ack;
  logic [WIDTH-1:0]   r_q;
  logic               w_any;
  logic [PTR_W-1:0]   w_pick;
  logic [PTR_W:0]     w_idx;
  logic [N_REQ-1:0]   w_pick_oh;
  logic [N_REQ-1:0]   w_sel_oh;
  logic [1:0]         w_ops [N_REQ];
  logic [WIDTH-1:0]   w_ds  [N_REQ];
  logic [1:0]         w_op;
  logic [WIDTH-1:0]   w_d;
  logic [WIDTH-1:0]   w_next;
  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign w_ops[i] = op[2*i +: 2];
    assign w_ds[i]  = d[WIDTH*i +: WIDTH];
  end
  // Scan downward so the last hit wins: that is the first requester at or after the pointer.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
      w_idx = (w_idx >= (PTR_W+1)'(N_REQ)) ? w_idx - (PTR_W+1)'(N_REQ) : w_idx;
      if (req[w_idx[PTR_W-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[PTR_W-1:0];
      end
    end
  end
  assign w_pick_oh = N_REQ'(1) << w_pick;
  assign w_sel_oh  = N_REQ'(1) << r_sel;
  assign w_op      = w_ops[r_sel];
  assign w_d       = w_ds[r_sel];
  assign w_next    = (w_op == 2'b00) ? w_d :
                     (w_op == 2'b01) ? '1 :
                     (w_op == 2'b10) ? '0 : r_q ^ w_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_last  <= '0;
      r_grant <= '0;
      r_ack   <= '0;
      r_q     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_sel   <= w_pick;
          r_grant <= w_pick_oh;
          r_state <= S_GRANT;
        end
        S_GRANT: if (req[r_sel]) begin
          r_q     <= w_next;
          r_ack   <= w_sel_oh;
          r_last  <= r_sel;
          r_state <= S_COMMIT;
        end else begin
          r_grant <= '0;
          r_state <= S_IDLE;
        end
        S_COMMIT: begin
          r_grant <= '0;
          r_ack   <= '0;
          r_ptr   <= (r_sel == PTR_W'(N_REQ - 1)) ? '0 : r_sel + 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign grant   = r_grant;
  assign ack     = r_ack;
  assign q       = r_q;
  assign busy    = (r_state != S_IDLE);
  assign last_id = r_last;
endmodule
